// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX FIFO push signals shared by uart_tx_arbiter
// master: arbiter side; slave: requesters plus FIFO side.
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [DWIDTH-1:0]      fifo_wdata;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output req_ack, grant, busy, fifo_wr, fifo_wdata
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  req_ack, grant, busy, fifo_wr, fifo_wdata
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter for the UART TX FIFO write port
// Define ARB_TIMEOUT_EN to release a locked grant after TIMEOUT cycles without a request.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]        state;
  logic [NREQ-1:0]   grant_q;
  logic [IW-1:0]     last_ptr;
  logic [IW-1:0]     g_idx;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic              push;
  logic              done;
  logic              release_lock;
  logic [DWIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DWIDTH +: DWIDTH];
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) g_idx = IW'(i);
    end
  end

  // Scan from farthest offset down so the slot right after the last winner ends up chosen.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_ptr) + k) % NREQ);
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign push           = (state == LOCK) && bus.req[g_idx] && !bus.fifo_full;
  assign done           = push && bus.req_last[g_idx];
  assign bus.fifo_wr    = push;
  assign bus.fifo_wdata = (state == LOCK) ? data_arr[g_idx] : '0;
  assign bus.req_ack    = push ? grant_q : '0;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state == LOCK);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;
  logic          expire;

  // A full FIFO with the requester still valid is not a stall; only a silent requester counts.
  assign expire = (state == LOCK) && !bus.req[g_idx] && (stall_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state != LOCK) || push || expire) begin
      stall_cnt <= '0;
    end else if (!bus.req[g_idx]) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

  assign release_lock = done || expire;
`else
  assign release_lock = done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      last_ptr <= IW'(NREQ - 1);
    end else if (state == IDLE) begin
      if (pick_vld) begin
        state   <= LOCK;
        grant_q <= NREQ'(1) << pick_idx;
      end
    end else if (release_lock) begin
      state    <= IDLE;
      grant_q  <= '0;
      last_ptr <= g_idx;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a packet-level model
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 2;
  localparam int DWIDTH  = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_src();
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [DWIDTH-1:0] d, input logic l);
    bus.req[i]                     = v;
    bus.req_data[i*DWIDTH +: DWIDTH] = d;
    bus.req_last[i]                = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_src();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_src();
    rst = 1'b1;
    bus.req = 2'b11;
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", bus.grant); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.fifo_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", bus.fifo_wr); else n_pass++;
    n_total++; if (bus.fifo_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", bus.fifo_wdata); else n_pass++;
    n_total++; if (bus.req_ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", bus.req_ack); else n_pass++;
    clear_src();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    set_src(0, 1'b1, 8'h41, 1'b0);
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b00) $display("FAIL single_arb_grant: got %b want 00", bus.grant); else n_pass++;
    n_total++; if (bus.fifo_wr !== 1'b0) $display("FAIL single_arb_wr: got %b want 0", bus.fifo_wr); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b01) $display("FAIL single_grant: got %b want 01", bus.grant); else n_pass++;
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h41) $display("FAIL single_byte0: got wr=%b data=%h want wr=1 data=41", bus.fifo_wr, bus.fifo_wdata); else n_pass++;
    n_total++; if (bus.req_ack !== 2'b01) $display("FAIL single_ack: got %b want 01", bus.req_ack); else n_pass++;
    next_cycle();
    set_src(0, 1'b1, 8'h42, 1'b1);
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h42) $display("FAIL single_byte1: got wr=%b data=%h want wr=1 data=42", bus.fifo_wr, bus.fifo_wdata); else n_pass++;
    next_cycle();
    set_src(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) $display("FAIL single_release: got grant=%b busy=%b want 00/0", bus.grant, bus.busy); else n_pass++;
    n_total++; if (bus.fifo_wr !== 1'b0) $display("FAIL single_idle_wr: got %b want 0", bus.fifo_wr); else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [7:0] base [NREQ];
    int         pos  [NREQ];
    logic [NREQ-1:0] acked;
    logic [7:0] got  [$];
    int         gotc [$];
    logic [7:0] want;
    int         c;
    do_reset();
    base[0] = 8'h10;
    base[1] = 8'h20;
    pos[0]  = 0;
    pos[1]  = 0;
    c       = 0;
    while (got.size() < 12 && c < 60) begin
      for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, base[i] + 8'(pos[i]), pos[i] == 2);
      @(negedge clk);
      acked = bus.req_ack;
      if (bus.fifo_wr === 1'b1) begin
        got.push_back(bus.fifo_wdata);
        gotc.push_back(c);
      end
      next_cycle();
      for (int i = 0; i < NREQ; i++) if (acked[i]) pos[i] = (pos[i] + 1) % 3;
      c++;
    end
    clear_src();
    n_total++; if (got.size() != 12) $display("FAIL rr_count: got %0d pushes want 12", got.size()); else n_pass++;
    if (got.size() == 12) begin
      n_total++; if (gotc[0] != 1) $display("FAIL rr_first_latency: got cycle %0d want 1", gotc[0]); else n_pass++;
      for (int k = 0; k < 12; k++) begin
        want = ((k % 6) < 3) ? 8'h10 + 8'(k % 3) : 8'h20 + 8'(k % 3);
        n_total++; if (got[k] !== want) $display("FAIL rr_data[%0d]: got %h want %h", k, got[k], want); else n_pass++;
        n_total++; if (gotc[k] != gotc[0] + k + k / 3) $display("FAIL rr_timing[%0d]: got cycle %0d want %0d", k, gotc[k], gotc[0] + k + k / 3); else n_pass++;
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_src(0, 1'b1, 8'hA0, 1'b0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'hA0) $display("FAIL full_pre: got wr=%b data=%h want 1/a0", bus.fifo_wr, bus.fifo_wdata); else n_pass++;
    next_cycle();
    set_src(0, 1'b1, 8'hA1, 1'b0);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++; if (bus.fifo_wr !== 1'b0) $display("FAIL full_wr[%0d]: got %b want 0", i, bus.fifo_wr); else n_pass++;
      n_total++; if (bus.req_ack !== 2'b00) $display("FAIL full_ack[%0d]: got %b want 00", i, bus.req_ack); else n_pass++;
      n_total++; if (bus.grant !== 2'b01) $display("FAIL full_grant[%0d]: got %b want 01", i, bus.grant); else n_pass++;
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'hA1) $display("FAIL full_resume: got wr=%b data=%h want 1/a1", bus.fifo_wr, bus.fifo_wdata); else n_pass++;
    next_cycle();
    set_src(0, 1'b1, 8'hA2, 1'b1);
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'hA2) $display("FAIL full_last: got wr=%b data=%h want 1/a2", bus.fifo_wr, bus.fifo_wdata); else n_pass++;
    next_cycle();
    clear_src();
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL full_release: got busy=%b want 0", bus.busy); else n_pass++;
    next_cycle();
  endtask

  task automatic test_req_drop();
    do_reset();
    set_src(1, 1'b1, 8'h20, 1'b0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b10 || bus.fifo_wdata !== 8'h20) $display("FAIL drop_first: got grant=%b data=%h want 10/20", bus.grant, bus.fifo_wdata); else n_pass++;
    next_cycle();
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h50, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (bus.grant !== 2'b10) $display("FAIL drop_grant[%0d]: got %b want 10", i, bus.grant); else n_pass++;
      n_total++; if (bus.fifo_wr !== 1'b0 || bus.req_ack !== 2'b00) $display("FAIL drop_idle[%0d]: got wr=%b ack=%b want 0/00", i, bus.fifo_wr, bus.req_ack); else n_pass++;
      next_cycle();
    end
    set_src(1, 1'b1, 8'h21, 1'b1);
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1 || bus.fifo_wdata !== 8'h21 || bus.req_ack !== 2'b10) $display("FAIL drop_resume: got wr=%b data=%h ack=%b want 1/21/10", bus.fifo_wr, bus.fifo_wdata, bus.req_ack); else n_pass++;
    next_cycle();
    set_src(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b00) $display("FAIL drop_gap: got %b want 00", bus.grant); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b01 || bus.fifo_wdata !== 8'h50) $display("FAIL drop_next: got grant=%b data=%h want 01/50", bus.grant, bus.fifo_wdata); else n_pass++;
    next_cycle();
    clear_src();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_src(0, 1'b1, 8'h60, 1'b0);
    set_src(1, 1'b1, 8'h70, 1'b0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.fifo_wr !== 1'b1) $display("FAIL rstmid_pre: got wr=%b want 1", bus.fifo_wr); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.fifo_wr !== 1'b0) $display("FAIL rstmid_async: got grant=%b busy=%b wr=%b want 00/0/0", bus.grant, bus.busy, bus.fifo_wr); else n_pass++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b01) $display("FAIL rstmid_winner: got %b want 01", bus.grant); else n_pass++;
    next_cycle();
    clear_src();
  endtask

  task automatic test_timeout();
    do_reset();
    set_src(1, 1'b1, 8'h30, 1'b0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h40, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      n_total++; if (bus.grant !== 2'b10 || bus.fifo_wr !== 1'b0) $display("FAIL to_hold[%0d]: got grant=%b wr=%b want 10/0", i, bus.grant, bus.fifo_wr); else n_pass++;
      next_cycle();
    end
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b00 || bus.req_ack !== 2'b00) $display("FAIL to_release: got grant=%b ack=%b want 00/00", bus.grant, bus.req_ack); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b01) $display("FAIL to_next: got %b want 01", bus.grant); else n_pass++;
    next_cycle();
`else
    repeat (100) next_cycle();
    @(negedge clk);
    n_total++; if (bus.grant !== 2'b10 || bus.fifo_wr !== 1'b0) $display("FAIL to_locked: got grant=%b wr=%b want 10/0", bus.grant, bus.fifo_wr); else n_pass++;
    next_cycle();
`endif
    clear_src();
  endtask

  task automatic test_random();
    int m_owner;
    int m_last;
    int m_stall;
    int c;
    int rem [NREQ];
    logic [7:0] cur_byte [NREQ];
    logic [NREQ-1:0] e_grant;
    logic [NREQ-1:0] e_ack;
    logic e_wr;
    logic [7:0] e_data;
    do_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_stall = 0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]      = $urandom_range(1, 4);
      cur_byte[i] = 8'($urandom);
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) set_src(i, $urandom_range(0, 99) < 70, cur_byte[i], rem[i] == 1);
      bus.fifo_full = ($urandom_range(0, 99) < 20);
      @(negedge clk);
      e_grant = '0;
      e_ack   = '0;
      e_wr    = 1'b0;
      e_data  = 8'h00;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_wr   = bus.req[m_owner] && !bus.fifo_full;
        e_data = bus.req_data[m_owner*DWIDTH +: DWIDTH];
        if (e_wr) e_ack[m_owner] = 1'b1;
      end
      n_total++; if (bus.grant !== e_grant) $display("FAIL rnd_grant@%0d: got %b want %b", cyc, bus.grant, e_grant); else n_pass++;
      n_total++; if (bus.busy !== (m_owner >= 0)) $display("FAIL rnd_busy@%0d: got %b want %b", cyc, bus.busy, m_owner >= 0); else n_pass++;
      n_total++; if (bus.fifo_wr !== e_wr) $display("FAIL rnd_wr@%0d: got %b want %b", cyc, bus.fifo_wr, e_wr); else n_pass++;
      n_total++; if (bus.req_ack !== e_ack) $display("FAIL rnd_ack@%0d: got %b want %b", cyc, bus.req_ack, e_ack); else n_pass++;
      if (e_wr) begin
        n_total++; if (bus.fifo_wdata !== e_data) $display("FAIL rnd_data@%0d: got %h want %h", cyc, bus.fifo_wdata, e_data); else n_pass++;
      end
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (bus.req[c] && m_owner < 0) m_owner = c;
        end
      end else if (e_wr) begin
        m_stall = 0;
        if (bus.req_last[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
`ifdef ARB_TIMEOUT_EN
      else if (!bus.req[m_owner]) begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          m_last  = m_owner;
          m_owner = -1;
          m_stall = 0;
        end
      end
`endif
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (e_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          cur_byte[i] = 8'($urandom);
        end
      end
    end
    clear_src();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_req_drop();
    test_reset_mid_packet();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
